regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the CPU writeback stage and a peripheral requester (controller buttons, collision/game-state flags).
- The CPU has priority. Peripheral writes are buffered in a small FIFO and drained on cycles when the CPU is not writing.
- A starvation limit forces a one-cycle CPU stall so the FIFO is always served eventually.
- Writes to protected registers are filtered out: r0 is hardwired zero and r8 is the free-running shift register.

Parameters:
- DEPTH, 4: peripheral FIFO entries; power of 2, minimum 2.
- MAX_WAIT, 8: maximum consecutive CPU grants while the FIFO is non-empty before a forced FIFO cycle.
- PROTECT_MASK, 32'h0000_0101: bit i set means writes to register i are dropped.

Ports:
- clock  in  1  single system clock, rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- cpu_we  in  1  CPU writeback request.
- cpu_wreg  in  5  CPU destination register.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU must hold its pipeline this cycle; its write inputs are ignored.
- per_valid  in  1  peripheral write request.
- per_wreg  in  5  peripheral destination register.
- per_wdata  in  32  peripheral write data.
- per_ready  out  1  FIFO can accept this cycle; equals not-full.
- rf_we  out  1  to ctrl_writeEnable.
- rf_wreg  out  5  to ctrl_writeReg.
- rf_wdata  out  32  to data_writeReg.
- rf_src_per  out  1  1 = current rf write came from the FIFO.
- drop_count  out  8  saturating count of protected-register writes dropped.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, ctrl_reset_n=0):
  - All outputs are 0 except per_ready=1.
  - FIFO is flushed, wait_cnt=0, state=NORMAL.
  - Reset asserted mid-operation discards queued writes and any pending rf write.
- Protection:
  - cpu_prot = cpu_we & PROTECT_MASK[cpu_wreg]. In NORMAL, a protected CPU write is dropped: no grant, drop_count +1.
  - A peripheral handshake (per_valid & per_ready) to a protected register is accepted but not enqueued; drop_count +1.
  - Both drops in the same cycle add +2. drop_count saturates at 255.
- FIFO:
  - Push on per_valid & per_ready. per_ready = !full, computed from registered occupancy.
  - A push while full is impossible, even if a pop happens in the same cycle.
  - No bypass: an entry pushed in cycle N is poppable in N+1 at the earliest.
  - Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- FSM state NORMAL:
  - cpu_stall=0.
  - If cpu_req (cpu_we & !cpu_prot), grant the CPU.
  - Otherwise, if the FIFO is non-empty, pop the head and grant the FIFO.
  - Otherwise, no grant.
- wait_cnt (in NORMAL):
  - Cleared when the FIFO is granted or the FIFO is empty.
  - Incremented when the CPU is granted while the FIFO is non-empty.
  - If the CPU is granted with the FIFO non-empty and wait_cnt == MAX_WAIT-1, the next state is FORCE.
- FSM state FORCE (exactly one cycle):
  - cpu_stall=1 (Moore output). cpu_we/cpu_wreg/cpu_wdata are ignored, and no drop is counted.
  - The FIFO head is popped and granted. The FIFO is guaranteed non-empty because pops only occur in the arbiter.
  - wait_cnt is cleared; the next state is NORMAL.
- Output timing:
  - A grant in cycle N drives rf_we=1 with the matching rf_wreg, rf_wdata and rf_src_per in cycle N+1 (registered, one-cycle latency).
  - With no grant, rf_we=0, and rf_wreg/rf_wdata hold their last values.
- Ordering: peripheral writes are committed in arrival order. Relative CPU/peripheral order to the same register follows grant order.

Test Plan:
- Reset, then idle: rf_we=0, per_ready=1, fifo_count=0, drop_count=0, cpu_stall=0 for 10 cycles. Assert ctrl_reset_n=0 mid-cycle with 3 queued entries: fifo_count goes to 0 immediately.
- CPU write only: cpu_we=1, cpu_wreg=5, cpu_wdata=32'hDEAD_BEEF in cycle N -> rf_we=1, rf_wreg=5, rf_wdata=32'hDEAD_BEEF, rf_src_per=0 in N+1.
- Peripheral drain: push regs 10, 11, 12 with data 1, 2, 3 while the CPU is idle. The writes appear on rf in order over consecutive cycles, each with rf_src_per=1, starting two cycles after the first push.
- Fill/backpressure:
  - Set DEPTH=4 and hold cpu_we=1 to reg 3.
  - Offer 6 peripheral writes -> per_ready drops after 4 are accepted and fifo_count=4.
  - The remaining 2 are held and are accepted only after pops.
- Starvation: FIFO holds 1 entry (reg 20, data 7) and the CPU writes reg 3 every cycle.
  - After exactly 8 CPU grants, cpu_stall=1 for one cycle.
  - reg 20=7 is written the next cycle with rf_src_per=1.
  - CPU writes resume afterwards with none lost (the bench re-presents the stalled write).
- Protection: in the same cycle, CPU writes reg 0 and the peripheral writes reg 8 -> no rf_we, drop_count=2. Repeat 200 times -> drop_count saturates at 255.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle shared by the CPU writeback stage, the peripheral requester
// and the register file, as seen from the requesters (master) and the arbiter (slave).
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
);
  logic                     cpu_we;
  logic [4:0]               cpu_wreg;
  logic [31:0]              cpu_wdata;
  logic                     cpu_stall;
  logic                     per_valid;
  logic [4:0]               per_wreg;
  logic [31:0]              per_wdata;
  logic                     per_ready;
  logic                     rf_we;
  logic [4:0]               rf_wreg;
  logic [31:0]              rf_wdata;
  logic                     rf_src_per;
  logic [7:0]               drop_count;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output cpu_we, cpu_wreg, cpu_wdata, per_valid, per_wreg, per_wdata,
    input  cpu_stall, per_ready, rf_we, rf_wreg, rf_wdata, rf_src_per,
           drop_count, fifo_count
  );

  modport slave (
    input  cpu_we, cpu_wreg, cpu_wdata, per_valid, per_wreg, per_wdata,
    output cpu_stall, per_ready, rf_we, rf_wreg, rf_wdata, rf_src_per,
           drop_count, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port: CPU first, peripheral writes queued
// in a FIFO, with a forced FIFO cycle after MAX_WAIT consecutive CPU wins.
module regfile_write_arbiter #(
  parameter int          DEPTH        = 4,
  parameter int          MAX_WAIT     = 8,
  parameter logic [31:0] PROTECT_MASK = 32'h0000_0101
) (
  input logic                    clock,
  input logic                    ctrl_reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, FORCE} state_e;

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wr_t;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  wr_t             mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            rf_we_q, rf_src_per_q;
  logic [4:0]      rf_wreg_q;
  logic [31:0]     rf_wdata_q;
  logic [7:0]      drop_q, drop_d;
  logic [8:0]      drop_sum;

  logic full, empty, push, enq, pop, grant, grant_per, cpu_drop, per_drop;
  wr_t  grant_wr;

  // Occupancy is registered, so per_ready never depends on this cycle's pop.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.per_valid & ~full;
  assign per_drop = push & PROTECT_MASK[bus.per_wreg];
  assign enq      = push & ~per_drop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    wait_d    = wait_q;
    pop       = 1'b0;
    grant     = 1'b0;
    grant_per = 1'b0;
    cpu_drop  = 1'b0;
    grant_wr  = mem_q[rd_ptr_q];
    case (state_q)
      NORMAL: begin
        cpu_drop = bus.cpu_we & PROTECT_MASK[bus.cpu_wreg];
        if (bus.cpu_we && !cpu_drop) begin
          grant    = 1'b1;
          grant_wr = '{wreg: bus.cpu_wreg, wdata: bus.cpu_wdata};
          if (empty) begin
            wait_d = '0;
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_q == WW'(MAX_WAIT - 1)) state_d = FORCE;
          end
        end else begin
          wait_d = '0;
          if (!empty) begin
            pop       = 1'b1;
            grant     = 1'b1;
            grant_per = 1'b1;
          end
        end
      end
      FORCE: begin
        // FIFO cannot be empty here: only this arbiter pops it.
        pop       = 1'b1;
        grant     = 1'b1;
        grant_per = 1'b1;
        wait_d    = '0;
        state_d   = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign drop_sum = {1'b0, drop_q} + 9'(cpu_drop) + 9'(per_drop);
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q      <= NORMAL;
      wait_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rf_we_q      <= 1'b0;
      rf_src_per_q <= 1'b0;
      rf_wreg_q    <= '0;
      rf_wdata_q   <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      drop_q       <= drop_d;
      count_q      <= count_q + CW'(enq) - CW'(pop);
      rf_we_q      <= grant;
      rf_src_per_q <= grant_per;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (grant) begin
        rf_wreg_q  <= grant_wr.wreg;
        rf_wdata_q <= grant_wr.wdata;
      end
    end
  end

  // NOTE: FIFO storage is not reset; pointers and occupancy decide which entries are valid.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= '{wreg: bus.per_wreg, wdata: bus.per_wdata};
  end

  assign bus.cpu_stall  = (state_q == FORCE);
  assign bus.per_ready  = ~full;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wreg    = rf_wreg_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_src_per = rf_src_per_q;
  assign bus.drop_count = drop_q;
  assign bus.fifo_count = count_q;
endmodule
